// File: rtl/game_screen_sequencer.sv
// ---------------------------------------------------------------------------
// game_screen_sequencer
//
// Top-level game-flow controller. It steps through the screen sequence
// (clear, start screen, wait for go, clear, maze, play, win/game-over screen,
// wait for go). It issues one draw request at a time to the full-screen
// drawer or to the maze renderer, and it waits for that unit's done. It
// routes the active unit's pixel stream to the VGA adapter, enables player
// movement during play, and keeps saturating win/loss tallies.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   key_go                       go key (synchronised level, polarity set by
//                                KEY_ACTIVE_LOW)
//   reached_exit, time_up        end-of-game conditions, used only in play
//   scr_done/x/y/colour          full-screen drawer status and pixel stream
//   maze_done/x/y/colour         maze renderer status and pixel stream
//   draw_clear/start/gameover/winner  one-hot screen draw requests
//   draw_maze                    maze render request
//   game_active                  player movement enable
//   vga_x/y/colour/plot          pixel write port to the VGA adapter
//   wins, losses                 saturating 8-bit game tallies
// ---------------------------------------------------------------------------
module game_screen_sequencer #(
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int GAP_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_go,
  input  logic       reached_exit,
  input  logic       time_up,
  input  logic       scr_done,
  input  logic [8:0] scr_x,
  input  logic [8:0] scr_y,
  input  logic [2:0] scr_colour,
  input  logic       maze_done,
  input  logic [8:0] maze_x,
  input  logic [8:0] maze_y,
  input  logic [2:0] maze_colour,
  output logic       draw_clear,
  output logic       draw_start,
  output logic       draw_gameover,
  output logic       draw_winner,
  output logic       draw_maze,
  output logic       game_active,
  output logic [8:0] vga_x,
  output logic [8:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [7:0] wins,
  output logic [7:0] losses
);

  typedef enum logic [3:0] {
    S_INIT_GAP   = 4'd0,
    S_CLR0       = 4'd1,
    S_START_DRAW = 4'd2,
    S_START_WAIT = 4'd3,
    S_CLR1       = 4'd4,
    S_MAZE_DRAW  = 4'd5,
    S_PLAY       = 4'd6,
    S_WIN_DRAW   = 4'd7,
    S_OVER_DRAW  = 4'd8,
    S_END_WAIT   = 4'd9,
    S_GAP        = 4'd10
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  // Tally increment that holds at the top value instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

  state_t     state_r, state_s;
  state_t     ret_r, ret_s;          // state to enter once the gap expires
  logic [3:0] gap_cnt_r;
  logic       armed_r;               // 1 from the second cycle spent in a state
  logic       go_prev_r;
  logic       key_pressed_s;
  logic       go_pulse_s;
  logic       gap_last_s;
  logic       scr_done_ok_s;
  logic       maze_done_ok_s;
  logic       win_inc_s;
  logic       loss_inc_s;
  logic       req_clear_s, req_start_s, req_gameover_s, req_winner_s, req_maze_s;
  logic       active_s;
  logic       draw_clear_r, draw_start_r, draw_gameover_r, draw_winner_r, draw_maze_r;
  logic       game_active_r;
  logic [7:0] wins_r, losses_r;
  logic       scr_req_s;

  assign key_pressed_s = KEY_ACTIVE_LOW ? ~key_go : key_go;
  assign go_pulse_s    = key_pressed_s & ~go_prev_r;
  assign gap_last_s    = (gap_cnt_r == GAP_LAST);
  // A done present on the first request cycle may be left over from the
  // previous draw, so it only counts once the request has been up a cycle.
  assign scr_done_ok_s  = armed_r & scr_done;
  assign maze_done_ok_s = armed_r & maze_done;

  // Next-state selection and single-cycle tally increment events.
  always_comb begin
    state_s    = state_r;
    ret_s      = ret_r;
    win_inc_s  = 1'b0;
    loss_inc_s = 1'b0;
    case (state_r)
      S_INIT_GAP: begin
        if (gap_last_s) state_s = S_CLR0;
        else            state_s = S_INIT_GAP;
      end
      S_GAP: begin
        if (gap_last_s) state_s = ret_r;
        else            state_s = S_GAP;
      end
      S_CLR0: begin
        if (scr_done_ok_s) begin
          state_s = S_GAP;
          ret_s   = S_START_DRAW;
        end else begin
          state_s = S_CLR0;
        end
      end
      S_START_DRAW: begin
        if (scr_done_ok_s) begin
          state_s = S_GAP;
          ret_s   = S_START_WAIT;
        end else begin
          state_s = S_START_DRAW;
        end
      end
      S_START_WAIT: begin
        if (go_pulse_s) begin
          state_s = S_GAP;
          ret_s   = S_CLR1;
        end else begin
          state_s = S_START_WAIT;
        end
      end
      S_CLR1: begin
        if (scr_done_ok_s) begin
          state_s = S_GAP;
          ret_s   = S_MAZE_DRAW;
        end else begin
          state_s = S_CLR1;
        end
      end
      S_MAZE_DRAW: begin
        // Different unit from the screen drawer, so no gap is needed.
        if (maze_done_ok_s) state_s = S_PLAY;
        else                state_s = S_MAZE_DRAW;
      end
      S_PLAY: begin
        // A win takes priority when both end conditions arrive together.
        if (reached_exit) begin
          win_inc_s = 1'b1;
          state_s   = S_GAP;
          ret_s     = S_WIN_DRAW;
        end else if (time_up) begin
          loss_inc_s = 1'b1;
          state_s    = S_GAP;
          ret_s      = S_OVER_DRAW;
        end else begin
          state_s = S_PLAY;
        end
      end
      S_WIN_DRAW: begin
        if (scr_done_ok_s) begin
          state_s = S_GAP;
          ret_s   = S_END_WAIT;
        end else begin
          state_s = S_WIN_DRAW;
        end
      end
      S_OVER_DRAW: begin
        if (scr_done_ok_s) begin
          state_s = S_GAP;
          ret_s   = S_END_WAIT;
        end else begin
          state_s = S_OVER_DRAW;
        end
      end
      S_END_WAIT: begin
        if (go_pulse_s) begin
          state_s = S_GAP;
          ret_s   = S_CLR0;
        end else begin
          state_s = S_END_WAIT;
        end
      end
      default: begin
        state_s = S_INIT_GAP;
        ret_s   = S_INIT_GAP;
      end
    endcase
  end

  // Request/enable decode from the next state so the registered outputs line
  // up with the state register.
  always_comb begin
    req_clear_s    = (state_s == S_CLR0) || (state_s == S_CLR1);
    req_start_s    = (state_s == S_START_DRAW);
    req_gameover_s = (state_s == S_OVER_DRAW);
    req_winner_s   = (state_s == S_WIN_DRAW);
    req_maze_s     = (state_s == S_MAZE_DRAW);
    active_s       = (state_s == S_PLAY);
  end

  // State, gap counter, go-edge detector, registered outputs and tallies.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r         <= S_INIT_GAP;
      ret_r           <= S_INIT_GAP;
      gap_cnt_r       <= 4'd0;
      armed_r         <= 1'b0;
      go_prev_r       <= 1'b0;
      draw_clear_r    <= 1'b0;
      draw_start_r    <= 1'b0;
      draw_gameover_r <= 1'b0;
      draw_winner_r   <= 1'b0;
      draw_maze_r     <= 1'b0;
      game_active_r   <= 1'b0;
      wins_r          <= 8'd0;
      losses_r        <= 8'd0;
    end else begin
      state_r   <= state_s;
      ret_r     <= ret_s;
      armed_r   <= (state_s == state_r);
      go_prev_r <= key_pressed_s;
      // The counter restarts on every entry into a gap-type state.
      if (((state_s == S_GAP) || (state_s == S_INIT_GAP)) && (state_s == state_r)) begin
        gap_cnt_r <= gap_cnt_r + 4'd1;
      end else begin
        gap_cnt_r <= 4'd0;
      end
      draw_clear_r    <= req_clear_s;
      draw_start_r    <= req_start_s;
      draw_gameover_r <= req_gameover_s;
      draw_winner_r   <= req_winner_s;
      draw_maze_r     <= req_maze_s;
      game_active_r   <= active_s;
      if (win_inc_s) begin
        wins_r <= sat_inc(wins_r);
      end else begin
        wins_r <= wins_r;
      end
      if (loss_inc_s) begin
        losses_r <= sat_inc(losses_r);
      end else begin
        losses_r <= losses_r;
      end
    end
  end

  assign scr_req_s = draw_clear_r | draw_start_r | draw_gameover_r | draw_winner_r;

  // Pixel mux: route the unit currently holding a request to the VGA port.
  always_comb begin
    vga_x      = 9'd0;
    vga_y      = 9'd0;
    vga_colour = 3'd0;
    vga_plot   = 1'b0;
    if (scr_req_s) begin
      vga_x      = scr_x;
      vga_y      = scr_y;
      vga_colour = scr_colour;
      vga_plot   = ~scr_done;
    end else if (draw_maze_r) begin
      vga_x      = maze_x;
      vga_y      = maze_y;
      vga_colour = maze_colour;
      vga_plot   = ~maze_done;
    end else begin
      vga_plot   = 1'b0;
    end
  end

  assign draw_clear    = draw_clear_r;
  assign draw_start    = draw_start_r;
  assign draw_gameover = draw_gameover_r;
  assign draw_winner   = draw_winner_r;
  assign draw_maze     = draw_maze_r;
  assign game_active   = game_active_r;
  assign wins          = wins_r;
  assign losses        = losses_r;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_screen_sequencer
//
// Directed bench for game_screen_sequencer. A small drawer/renderer model
// answers requests after a programmable latency. Expected requests (kind,
// idle cycles before it, number of cycles high) are queued as stimulus is
// applied. They are checked as the DUT raises and drops each request.
// ---------------------------------------------------------------------------
module tb_game_screen_sequencer;

  localparam int C_CLEAR = 1;
  localparam int C_START = 2;
  localparam int C_OVER  = 3;
  localparam int C_WIN   = 4;
  localparam int C_MAZE  = 5;

  logic       clk = 1'b0;
  logic       resetn;
  logic       key_go;
  logic       reached_exit;
  logic       time_up;
  logic       scr_done;
  logic [8:0] scr_x, scr_y;
  logic [2:0] scr_colour;
  logic       maze_done;
  logic [8:0] maze_x, maze_y;
  logic [2:0] maze_colour;
  logic       draw_clear, draw_start, draw_gameover, draw_winner, draw_maze;
  logic       game_active;
  logic [8:0] vga_x, vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [7:0] wins, losses;

  typedef struct {
    int code;
    int gap;   // expected idle cycles before the request, -1 = not checked
    int len;   // expected cycles the request stays high
  } item_t;

  item_t q[$];
  item_t cur;
  bit    cur_valid = 1'b0;
  int    errors = 0;
  int    checks = 0;
  int    prev_code = 0;
  int    run_len = 0;
  int    idle_cnt = 0;
  int    scr_cnt = 0;
  int    maze_cnt = 0;
  int    scr_lat = 5;
  int    maze_lat = 3;
  bit    scr_stuck = 1'b0;

  game_screen_sequencer #(.KEY_ACTIVE_LOW(1'b1), .GAP_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn), .key_go(key_go),
    .reached_exit(reached_exit), .time_up(time_up),
    .scr_done(scr_done), .scr_x(scr_x), .scr_y(scr_y), .scr_colour(scr_colour),
    .maze_done(maze_done), .maze_x(maze_x), .maze_y(maze_y), .maze_colour(maze_colour),
    .draw_clear(draw_clear), .draw_start(draw_start), .draw_gameover(draw_gameover),
    .draw_winner(draw_winner), .draw_maze(draw_maze), .game_active(game_active),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .wins(wins), .losses(losses)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int req_code();
    if (draw_clear === 1'b1)    return C_CLEAR;
    if (draw_start === 1'b1)    return C_START;
    if (draw_gameover === 1'b1) return C_OVER;
    if (draw_winner === 1'b1)   return C_WIN;
    if (draw_maze === 1'b1)     return C_MAZE;
    return 0;
  endfunction

  task automatic push(input int code, input int gap, input int len);
    item_t it;
    it.code = code;
    it.gap  = gap;
    it.len  = len;
    q.push_back(it);
  endtask

  // One clock: sample away from the edge, check, then drive the unit models.
  task automatic step();
    int  code;
    bit  scr_req;
    logic [8:0] ex, ey;
    logic [2:0] ec;
    logic       ep;
    @(posedge clk);
    #1;
    code = req_code();
    check("onehot", 32'($countones({draw_clear, draw_start, draw_gameover,
                                    draw_winner, draw_maze}) <= 1), 32'd1);
    scr_req = draw_clear | draw_start | draw_gameover | draw_winner;
    if (scr_req) begin
      ex = scr_x; ey = scr_y; ec = scr_colour; ep = ~scr_done;
    end else if (draw_maze) begin
      ex = maze_x; ey = maze_y; ec = maze_colour; ep = ~maze_done;
    end else begin
      ex = 9'd0; ey = 9'd0; ec = 3'd0; ep = 1'b0;
    end
    check("vga_x", 32'(vga_x), 32'(ex));
    check("vga_y", 32'(vga_y), 32'(ey));
    check("vga_colour", 32'(vga_colour), 32'(ec));
    check("vga_plot", 32'(vga_plot), 32'(ep));
    if (code != prev_code) begin
      if (prev_code != 0 && cur_valid) begin
        check("req_len", run_len, cur.len);
        cur_valid = 1'b0;
      end
      if (prev_code == C_MAZE && code == 0) check("active_after_maze", 32'(game_active), 32'd1);
      if (code != 0) begin
        if (q.size() == 0) begin
          check("unexpected_req", code, 0);
        end else begin
          cur = q.pop_front();
          cur_valid = 1'b1;
          check("req_kind", code, cur.code);
          if (cur.gap >= 0) check("req_gap", idle_cnt, cur.gap);
        end
      end
      run_len = 0;
    end
    if (code != 0) begin
      run_len++;
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
    prev_code = code;
    // Unit models: done rises after the latency and is sticky while requested.
    if (scr_req) scr_cnt++; else scr_cnt = 0;
    scr_done = scr_stuck || (scr_req && scr_cnt > scr_lat);
    if (draw_maze) maze_cnt++; else maze_cnt = 0;
    maze_done = draw_maze && maze_cnt > maze_lat;
    scr_x = 9'($urandom_range(0, 511));
    scr_y = 9'($urandom_range(0, 511));
    scr_colour = 3'($urandom_range(0, 7));
    maze_x = 9'($urandom_range(0, 511));
    maze_y = 9'($urandom_range(0, 511));
    maze_colour = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound && (q.size() != 0 || cur_valid); i++) step();
    check(tag, 32'(q.size() == 0 && !cur_valid), 32'd1);
  endtask

  task automatic wait_active(input string tag, input int bound);
    for (int i = 0; i < bound && game_active !== 1'b1; i++) step();
    check(tag, 32'(game_active), 32'd1);
  endtask

  // Let the gap finish, then press and release the go key (pressed = 0).
  task automatic press_go();
    repeat (3) step();
    key_go = 1'b0;
    step();
    key_go = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; key_go = 1'b1; reached_exit = 1'b0; time_up = 1'b0;
    scr_done = 1'b0; maze_done = 1'b0;
    scr_x = 9'd0; scr_y = 9'd0; scr_colour = 3'd0;
    maze_x = 9'd0; maze_y = 9'd0; maze_colour = 3'd0;
    repeat (3) step();
    check("rst_req", req_code(), 0);
    check("rst_active", 32'(game_active), 32'd0);
    check("rst_wins", 32'(wins), 32'd0);
    check("rst_losses", 32'(losses), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);

    // Power-up: clear (done after 5 cycles -> 6 high), 2 idle, start screen.
    push(C_CLEAR, -1, 6);
    push(C_START, 2, 6);
    resetn = 1'b1;
    wait_idle("boot_seq", 100);
    repeat (5) step();
    check("start_wait_req", req_code(), 0);
    check("start_wait_plot", 32'(vga_plot), 32'd0);

    // Holding go for 50 cycles gives exactly one clear + maze sequence.
    push(C_CLEAR, -1, 6);
    push(C_MAZE, 2, 4);
    key_go = 1'b0;
    repeat (50) step();
    key_go = 1'b1;
    check("hold_one_seq", 32'(q.size() == 0 && !cur_valid), 32'd1);
    check("play_active", 32'(game_active), 32'd1);

    // Win and time-up together: win wins, winner screen after two gap cycles.
    reached_exit = 1'b1; time_up = 1'b1;
    push(C_WIN, -1, 6);
    step();
    reached_exit = 1'b0; time_up = 1'b0;
    check("both_wins", 32'(wins), 32'd1);
    check("both_losses", 32'(losses), 32'd0);
    check("both_inactive", 32'(game_active), 32'd0);
    check("win_gap1", 32'(draw_winner), 32'd0);
    step();
    check("win_gap2", 32'(draw_winner), 32'd0);
    step();
    check("win_draw", 32'(draw_winner), 32'd1);
    wait_idle("win_seq", 100);

    // Go from END_WAIT restarts at the start screen; tallies survive.
    push(C_CLEAR, -1, 6);
    push(C_START, 2, 6);
    press_go();
    wait_idle("restart_seq", 100);
    check("keep_wins", 32'(wins), 32'd1);
    check("keep_losses", 32'(losses), 32'd0);

    // Second game lost on time_up.
    push(C_CLEAR, -1, 6);
    push(C_MAZE, 2, 4);
    press_go();
    wait_active("wait_play2", 100);
    time_up = 1'b1;
    push(C_OVER, -1, 6);
    step();
    time_up = 1'b0;
    check("loss_inc", 32'(losses), 32'd1);
    check("loss_wins", 32'(wins), 32'd1);
    // Go pressed during the game-over draw is dropped, and holding it gives
    // no new pulse once END_WAIT is reached.
    step();
    key_go = 1'b0;
    wait_idle("over_seq", 100);
    reached_exit = 1'b1; time_up = 1'b1;
    repeat (8) step();
    reached_exit = 1'b0; time_up = 1'b0; key_go = 1'b1;
    check("end_wait_idle", req_code(), 0);
    check("ignored_wins", 32'(wins), 32'd1);
    check("ignored_losses", 32'(losses), 32'd1);

    // Reset while the start screen is mid-draw, with done stuck high.
    push(C_CLEAR, -1, 6);
    push(C_START, 2, 6);
    press_go();
    for (int i = 0; i < 100 && draw_start !== 1'b1; i++) step();
    check("reach_start", 32'(draw_start), 32'd1);
    repeat (2) step();
    q.delete();
    cur_valid = 1'b0;
    scr_stuck = 1'b1;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("mid_rst_req", req_code(), 0);
    check("mid_rst_wins", 32'(wins), 32'd0);
    check("mid_rst_losses", 32'(losses), 32'd0);
    check("mid_rst_active", 32'(game_active), 32'd0);
    // Stale done is ignored on the first cycle, taken on the second.
    push(C_CLEAR, 2, 2);
    wait_idle("stuck_clear", 100);
    scr_stuck = 1'b0;
    push(C_START, 2, 6);
    wait_idle("after_stuck", 100);

    // 256 fast wins: tally saturates at 255.
    scr_lat = 1;
    maze_lat = 1;
    for (int i = 0; i < 256; i++) begin
      push(C_CLEAR, -1, 2);
      push(C_MAZE, 2, 2);
      press_go();
      wait_active("sat_play", 100);
      reached_exit = 1'b1;
      push(C_WIN, -1, 2);
      step();
      reached_exit = 1'b0;
      check("sat_wins", 32'(wins), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      wait_idle("sat_win_seq", 100);
      push(C_CLEAR, -1, 2);
      push(C_START, 2, 2);
      press_go();
      wait_idle("sat_restart", 100);
    end
    check("sat_final", 32'(wins), 32'd255);
    check("sat_losses", 32'(losses), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
